// File: rtl/seed_rx_collector.sv
`default_nettype none
// =============================================================================
// seed_rx_collector : packs SEED byte-serial output into 128-bit blocks + FIFO
// Revision 1.0
// =============================================================================
module seed_rx_collector #(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [7:0]   Cryp_in,
   input  logic         valid_in,
   output logic [127:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         frame_err,
   output logic         overflow,
   output logic [15:0]  blk_count
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [3:0]         byte_cnt;
   logic [127:0]       asm_reg;
   logic [127:0]       asm_next;
   logic               block_done;
   logic               abort;

   logic [127:0]       mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     occ;
   logic               full;
   logic               pop;
   logic               push;

   assign asm_next = {asm_reg[119:0], Cryp_in};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      block_done = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (valid_in) begin
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (!valid_in) begin
               state_nxt = IDLE;
               abort     = 1'b1;
            end else if (byte_cnt == 4'd15) begin
               state_nxt  = IDLE;
               block_done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The counter wraps 15->0 on its own, so a 17th valid byte starts a new frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt <= 4'd0;
         asm_reg  <= '0;
      end else if (valid_in) begin
         byte_cnt <= byte_cnt + 4'd1;
         asm_reg  <= asm_next;
      end else begin
         byte_cnt <= 4'd0;
      end
   end

   assign blk_valid = (occ != '0);
   assign full      = (occ == FULL_OCC);
   assign pop       = blk_valid && blk_ready;
   assign push      = block_done && (!full || pop);
   assign blk_data  = blk_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= asm_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occ       <= '0;
         blk_count <= 16'd0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= abort;
         overflow  <= block_done && full && !pop;
         if (push) begin
            wr_ptr    <= wr_ptr + PTR_W'(1);
            blk_count <= blk_count + 16'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + (PTR_W + 1)'(1);
            2'b01:   occ <= occ - (PTR_W + 1)'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seed_rx_collector.sv
`default_nettype none
// =============================================================================
// tb_seed_rx_collector : scoreboard bench with a frame/queue reference model
// Revision 1.0
// =============================================================================
module tb_seed_rx_collector;

   localparam int DEPTH = 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [7:0]   Cryp_in = 8'd0;
   logic         valid_in = 1'b0;
   logic         blk_ready = 1'b0;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         frame_err;
   logic         overflow;
   logic [15:0]  blk_count;

   int checks = 0;
   int failures = 0;

   logic [127:0] exp_q[$];
   logic [7:0]   frame[$];
   int           mocc = 0;
   logic [15:0]  mcount = 16'd0;
   logic         exp_ferr = 1'b0;
   logic         exp_ovf = 1'b0;
   bit           m_pop;
   bit           m_acc;
   logic [127:0] m_blk;

   seed_rx_collector #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .Cryp_in   (Cryp_in),
      .valid_in  (valid_in),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .frame_err (frame_err),
      .overflow  (overflow),
      .blk_count (blk_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      frame.delete();
      exp_q.delete();
      mocc     = 0;
      mcount   = 16'd0;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
   endtask

   // Reference model: collect bytes into frames, track buffer occupancy as a count.
   always @(posedge clk) begin
      if (!reset_n) begin
         clear_model();
      end else begin
         m_pop    = (mocc > 0) && blk_ready;
         m_acc    = 1'b0;
         exp_ferr = 1'b0;
         exp_ovf  = 1'b0;
         if (valid_in) begin
            frame.push_back(Cryp_in);
            if (frame.size() == 16) begin
               m_blk = '0;
               foreach (frame[i]) m_blk = {m_blk[119:0], frame[i]};
               frame.delete();
               if (mocc < DEPTH || m_pop) begin
                  exp_q.push_back(m_blk);
                  mcount = mcount + 16'd1;
                  m_acc  = 1'b1;
               end else begin
                  exp_ovf = 1'b1;
               end
            end
         end else if (frame.size() > 0) begin
            frame.delete();
            exp_ferr = 1'b1;
         end
         mocc = mocc - int'(m_pop) + int'(m_acc);
      end
   end

   // Monitor: compares the head block and status outputs away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("blk_valid", blk_valid, mocc != 0);
         chk("frame_err", frame_err, exp_ferr);
         chk("overflow", overflow, exp_ovf);
         chk("blk_count", blk_count, mcount);
         if (mocc != 0 && exp_q.size() > 0) begin
            chk("blk_data", blk_data, exp_q[0]);
            if (blk_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step(input bit v, input logic [7:0] b, input bit r);
      valid_in  = v;
      Cryp_in   = b;
      blk_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] start, input bit r);
      for (int i = 0; i < 16; i++) step(1'b1, start + 8'(i), r);
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, r);
   endtask

   task automatic do_reset();
      valid_in  = 1'b0;
      blk_ready = 1'b0;
      reset_n   = 1'b0;
      #1;
      chk("rst_blk_valid", blk_valid, 1'b0);
      chk("rst_blk_data", blk_data, 128'd0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_blk_count", blk_count, 16'd0);
      clear_model();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();

      // single frame
      send_frame(8'h00, 1'b1);
      chk("single_valid", blk_valid, 1'b1);
      chk("single_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
      idle(1, 1'b1);
      chk("single_valid_drop", blk_valid, 1'b0);
      chk("single_count", blk_count, 16'd1);
      idle(2, 1'b1);

      // short frame then a good frame
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 8'h40 + 8'(i), 1'b1);
      step(1'b0, 8'd0, 1'b1);
      chk("short_ferr", frame_err, 1'b1);
      step(1'b0, 8'd0, 1'b1);
      chk("short_ferr_once", frame_err, 1'b0);
      chk("short_count", blk_count, 16'd0);
      send_frame(8'hA0, 1'b1);
      chk("after_short_data", blk_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      idle(3, 1'b1);

      // back-to-back frames
      do_reset();
      for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b1);
      idle(3, 1'b1);
      chk("b2b_count", blk_count, 16'd2);

      // overflow with consumer stalled
      do_reset();
      send_frame(8'h00, 1'b0);
      send_frame(8'h10, 1'b0);
      send_frame(8'h20, 1'b0);
      chk("ovf_pulse", overflow, 1'b1);
      chk("ovf_count", blk_count, 16'd2);
      idle(1, 1'b0);
      chk("ovf_once", overflow, 1'b0);
      chk("ovf_head", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
      idle(4, 1'b1);

      // full buffer with a pop on the completing edge
      do_reset();
      send_frame(8'h00, 1'b0);
      send_frame(8'h10, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
      step(1'b1, 8'h2F, 1'b1);
      chk("fullpop_ovf", overflow, 1'b0);
      chk("fullpop_count", blk_count, 16'd3);
      chk("fullpop_head", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
      idle(1, 1'b0);
      idle(4, 1'b1);

      // reset mid-frame
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b1);
      do_reset();
      idle(2, 1'b1);
      send_frame(8'hC0, 1'b1);
      chk("midrst_data", blk_data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
      idle(2, 1'b1);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 15) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      idle(8, 1'b1);
      chk("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
